// File: rtl/lock_pkg.sv
// lock_pkg: shared definitions for the code-entry lock.
//   state_t   - gate states; the encoding doubles as the gate_status output
//               and is imported by the display stage.
//   DIGIT_MAX - largest switch value accepted as a code digit.
//   BTN_*     - bit positions of the buttons in the edge-detector bank.
package lock_pkg;

  typedef enum logic [2:0] {
    ST_LOCKED   = 3'b001,
    ST_WRONG    = 3'b010,
    ST_LOCKOUT  = 3'b011,
    ST_OPEN     = 3'b100,
    ST_NEW_CODE = 3'b101,
    ST_CONFIRM  = 3'b110
  } state_t;

  localparam logic [3:0] DIGIT_MAX = 4'd9;

  localparam int NUM_BTNS   = 3;
  localparam int BTN_ENTER  = 0;
  localparam int BTN_CHANGE = 1;
  localparam int BTN_CLEAR  = 2;

endpackage

// File: rtl/lock_fsm_button_edge.sv
// button_edge: registered rising-edge detector for one debounced button.
//   clk, reset - clock, async active-high reset
//   level      - debounced button level
//   rise       - high for one cycle after the registered level goes 0->1
// Both registers reset to 1 so a button held across reset release is not
// mistaken for a fresh press.
module button_edge (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic cur, prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur  <= 1'b1;
      prev <= 1'b1;
    end else begin
      cur  <= level;
      prev <= cur;
    end
  end

  assign rise = cur & ~prev;

endmodule

// File: rtl/lock_fsm.sv
// lock_fsm: four-digit code-entry state machine for the digital lock.
//   clk, reset            - clock, async active-high reset
//   digit                 - current switch value
//   btn_enter/change/clear - debounced button levels
//   gate_status           - state encoding (lock_pkg::state_t)
//   digit_index           - next digit position to be written
//   entry                 - digits entered so far, digit 0 in [15:12]
//   fail_count            - consecutive wrong entries
//   code_updated          - one-cycle pulse on the first OPEN cycle after a
//                           successful code change
module lock_fsm
  import lock_pkg::*;
#(
  parameter logic [15:0] DEFAULT_CODE  = 16'h1234,
  parameter int unsigned MAX_FAILS     = 3,
  parameter logic [23:0] WRONG_TICKS   = 24'd200,
  parameter logic [23:0] LOCKOUT_TICKS = 24'd2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  digit,
  input  logic        btn_enter,
  input  logic        btn_change,
  input  logic        btn_clear,
  output logic [2:0]  gate_status,
  output logic [1:0]  digit_index,
  output logic [15:0] entry,
  output logic [2:0]  fail_count,
  output logic        code_updated
);

  localparam logic [2:0] MAX_F = 3'(MAX_FAILS);

  logic [NUM_BTNS-1:0] rise;

  button_edge u_btn [NUM_BTNS-1:0] (
    .clk   (clk),
    .reset (reset),
    .level ({btn_clear, btn_change, btn_enter}),
    .rise  (rise)
  );

  wire ent = rise[BTN_ENTER];
  wire chg = rise[BTN_CHANGE];
  wire clr = rise[BTN_CLEAR];

  state_t      state, state_n;
  logic [15:0] code, code_n, pending, pending_n, entry_n, full;
  logic [1:0]  idx_n;
  logic [2:0]  fail_n, fail_inc;
  logic [23:0] timer, timer_n;
  logic        upd_n;
  logic [3:0]  shamt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_LOCKED;
      entry        <= '0;
      digit_index  <= '0;
      fail_count   <= '0;
      code         <= DEFAULT_CODE;
      pending      <= '0;
      timer        <= '0;
      code_updated <= 1'b0;
    end else begin
      state        <= state_n;
      entry        <= entry_n;
      digit_index  <= idx_n;
      fail_count   <= fail_n;
      code         <= code_n;
      pending      <= pending_n;
      timer        <= timer_n;
      code_updated <= upd_n;
    end
  end

  // The 4th digit is compared straight off the switches on the same edge it
  // is accepted, so the full word is assembled combinationally.
  assign full     = {entry[15:4], digit};
  assign fail_inc = fail_count + 3'd1;
  // Nibble for position idx sits at bit 4*(3-idx); 3-idx == ~idx for 2 bits.
  assign shamt    = {~digit_index, 2'b00};

  always_comb begin
    state_n   = state;
    entry_n   = entry;
    idx_n     = digit_index;
    fail_n    = fail_count;
    code_n    = code;
    pending_n = pending;
    timer_n   = timer;
    upd_n     = 1'b0;

    case (state)
      ST_LOCKED, ST_NEW_CODE, ST_CONFIRM: begin
        if (clr) begin
          entry_n = '0;
          idx_n   = '0;
        end else if (ent && digit <= DIGIT_MAX) begin
          if (digit_index == 2'd3) begin
            entry_n = '0;
            idx_n   = '0;
            if (state == ST_LOCKED) begin
              if (full == code) begin
                state_n = ST_OPEN;
                fail_n  = '0;
              end else begin
                fail_n  = fail_inc;
                timer_n = '0;
                state_n = (fail_inc == MAX_F) ? ST_LOCKOUT : ST_WRONG;
              end
            end else if (state == ST_NEW_CODE) begin
              pending_n = full;
              state_n   = ST_CONFIRM;
            end else begin
              if (full == pending) begin
                code_n = pending;
                upd_n  = 1'b1;
              end
              state_n = ST_OPEN;
            end
          end else begin
            entry_n = entry | ({12'd0, digit} << shamt);
            idx_n   = digit_index + 2'd1;
          end
        end
      end
      ST_WRONG: begin
        if (timer == WRONG_TICKS - 24'd1) begin
          state_n = ST_LOCKED;
          timer_n = '0;
        end else begin
          timer_n = timer + 24'd1;
        end
      end
      ST_LOCKOUT: begin
        if (timer == LOCKOUT_TICKS - 24'd1) begin
          state_n = ST_LOCKED;
          timer_n = '0;
          fail_n  = '0;
        end else begin
          timer_n = timer + 24'd1;
        end
      end
      ST_OPEN: begin
        if (ent)      state_n = ST_LOCKED;
        else if (chg) state_n = ST_NEW_CODE;
      end
      default: state_n = ST_LOCKED;
    endcase
  end

  assign gate_status = state;

endmodule

// File: tb/tb_lock_fsm.sv
// tb_lock_fsm: directed scoreboard bench for lock_fsm. Stimulus pushes the
// expected output snapshot and the cycle it should appear; a monitor pops
// and compares every time the DUT outputs change.
module tb_lock_fsm;

  localparam logic [2:0] G_L = 3'b001, G_W = 3'b010, G_X = 3'b011,
                         G_O = 3'b100, G_N = 3'b101, G_C = 3'b110;
  localparam logic [2:0] ENT = 3'b001, CHG = 3'b010, CLR = 3'b100;

  logic        clk = 1'b0, reset = 1'b1;
  logic [3:0]  digit = 4'd0;
  logic        btn_enter = 1'b0, btn_change = 1'b0, btn_clear = 1'b0;
  logic [2:0]  gate_status;
  logic [1:0]  digit_index;
  logic [15:0] entry;
  logic [2:0]  fail_count;
  logic        code_updated;

  lock_fsm #(
    .DEFAULT_CODE(16'h1234), .MAX_FAILS(3),
    .WRONG_TICKS(24'd200), .LOCKOUT_TICKS(24'd2000)
  ) dut (
    .clk(clk), .reset(reset), .digit(digit),
    .btn_enter(btn_enter), .btn_change(btn_change), .btn_clear(btn_clear),
    .gate_status(gate_status), .digit_index(digit_index), .entry(entry),
    .fail_count(fail_count), .code_updated(code_updated)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [2:0]  g;
    logic [1:0]  i;
    logic [15:0] e;
    logic [2:0]  f;
    logic        u;
  } exp_t;

  exp_t  eq[$];
  int    cq[$];
  string nq[$];
  int    errors = 0, checks = 0, last_cyc = 0;

  function automatic exp_t mk(logic [2:0] g, logic [1:0] i, logic [15:0] e,
                              logic [2:0] f, logic u);
    exp_t r;
    r.g = g; r.i = i; r.e = e; r.f = f; r.u = u;
    return r;
  endfunction

  function automatic exp_t snap();
    return mk(gate_status, digit_index, entry, fail_count, code_updated);
  endfunction

  task automatic push(input exp_t e, input int c, input string n);
    eq.push_back(e); cq.push_back(c); nq.push_back(n);
    last_cyc = c;
  endtask

  // Drive one button pattern for a cycle; outputs move two edges later.
  task automatic press(input logic [3:0] d, input logic [2:0] b,
                       input bit chg, input exp_t e, input string n);
    @(negedge clk);
    digit = d;
    {btn_clear, btn_change, btn_enter} = b;
    if (chg) push(e, cyc + 2, n);
    @(negedge clk);
    {btn_clear, btn_change, btn_enter} = 3'b000;
    @(negedge clk);
  endtask

  task automatic enter4(input logic [15:0] code, input logic [2:0] g,
                        input logic [2:0] f, input exp_t fin, input string n);
    logic [15:0] m;
    for (int k = 0; k < 4; k++) begin
      m = 16'hFFFF << (4 * (3 - k));
      if (k < 3)
        press(code[15-4*k -: 4], ENT, 1'b1, mk(g, 2'(k + 1), code & m, f, 1'b0),
              $sformatf("%s_d%0d", n, k));
      else
        press(code[3:0], ENT, 1'b1, fin, n);
    end
  endtask

  task automatic drain(input int lim, input string n);
    for (int k = 0; k < lim && eq.size() != 0; k++) @(negedge clk);
    checks++;
    if (eq.size() != 0) begin
      errors++;
      $display("FAIL drain_%s: %0d expected changes never seen, next=%s",
               n, eq.size(), nq[0]);
      eq.delete(); cq.delete(); nq.delete();
    end
  endtask

  task automatic check_now(input exp_t e, input string n);
    exp_t s;
    s = snap();
    checks++;
    if (s !== e) begin
      errors++;
      $display("FAIL %s: got g=%b i=%0d e=%h f=%0d u=%b, want g=%b i=%0d e=%h f=%0d u=%b",
               n, s.g, s.i, s.e, s.f, s.u, e.g, e.i, e.e, e.f, e.u);
    end
  endtask

  initial begin
    fork
      begin : monitor
        exp_t  last, s, e;
        int    c;
        string n;
        last = mk(G_L, 2'd0, 16'h0, 3'd0, 1'b0);
        forever begin
          @(negedge clk);
          s = snap();
          if (s !== last) begin
            checks++;
            if (eq.size() == 0) begin
              errors++;
              $display("FAIL unexpected_change: got g=%b i=%0d e=%h f=%0d u=%b at cyc %0d",
                       s.g, s.i, s.e, s.f, s.u, cyc);
            end else begin
              e = eq.pop_front(); c = cq.pop_front(); n = nq.pop_front();
              if (s !== e || cyc != c) begin
                errors++;
                $display("FAIL %s: got g=%b i=%0d e=%h f=%0d u=%b @%0d, want g=%b i=%0d e=%h f=%0d u=%b @%0d",
                         n, s.g, s.i, s.e, s.f, s.u, cyc, e.g, e.i, e.e, e.f, e.u, c);
              end
            end
            last = s;
          end
        end
      end
    join_none

    repeat (2) @(negedge clk);
    check_now(mk(G_L, 2'd0, 16'h0, 3'd0, 1'b0), "reset_state");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Unlock with the default code, then relock.
    enter4(16'h1234, G_L, 3'd0, mk(G_O, 2'd0, 16'h0, 3'd0, 1'b0), "open_default");
    press(4'd0, ENT, 1'b1, mk(G_L, 2'd0, 16'h0, 3'd0, 1'b0), "relock1");
    drain(10, "open_default");

    // Three wrong entries: two WRONG holds, then lockout.
    enter4(16'h5555, G_L, 3'd0, mk(G_W, 2'd0, 16'h0, 3'd1, 1'b0), "wrong1");
    push(mk(G_L, 2'd0, 16'h0, 3'd1, 1'b0), last_cyc + 200, "wrong1_exit");
    press(4'd5, ENT, 1'b0, '0, "");
    press(4'd0, CLR, 1'b0, '0, "");
    drain(300, "wrong1");
    enter4(16'h5555, G_L, 3'd1, mk(G_W, 2'd0, 16'h0, 3'd2, 1'b0), "wrong2");
    push(mk(G_L, 2'd0, 16'h0, 3'd2, 1'b0), last_cyc + 200, "wrong2_exit");
    drain(300, "wrong2");
    enter4(16'h5555, G_L, 3'd2, mk(G_X, 2'd0, 16'h0, 3'd3, 1'b0), "lockout");
    push(mk(G_L, 2'd0, 16'h0, 3'd0, 1'b0), last_cyc + 2000, "lockout_exit");
    press(4'd5, ENT, 1'b0, '0, "");
    press(4'd0, CHG, 1'b0, '0, "");
    drain(2100, "lockout");

    // Change with mismatched confirm: code stays 1234, no pulse.
    enter4(16'h1234, G_L, 3'd0, mk(G_O, 2'd0, 16'h0, 3'd0, 1'b0), "open2");
    press(4'd0, CHG, 1'b1, mk(G_N, 2'd0, 16'h0, 3'd0, 1'b0), "change1");
    enter4(16'h9876, G_N, 3'd0, mk(G_C, 2'd0, 16'h0, 3'd0, 1'b0), "newcode1");
    enter4(16'h9875, G_C, 3'd0, mk(G_O, 2'd0, 16'h0, 3'd0, 1'b0), "confirm_bad");
    press(4'd0, ENT, 1'b1, mk(G_L, 2'd0, 16'h0, 3'd0, 1'b0), "relock2");
    enter4(16'h1234, G_L, 3'd0, mk(G_O, 2'd0, 16'h0, 3'd0, 1'b0), "still_1234");
    drain(10, "confirm_bad");

    // Successful change to 9876 with a one-cycle pulse.
    press(4'd0, CHG, 1'b1, mk(G_N, 2'd0, 16'h0, 3'd0, 1'b0), "change2");
    enter4(16'h9876, G_N, 3'd0, mk(G_C, 2'd0, 16'h0, 3'd0, 1'b0), "newcode2");
    enter4(16'h9876, G_C, 3'd0, mk(G_O, 2'd0, 16'h0, 3'd0, 1'b1), "confirm_ok");
    push(mk(G_O, 2'd0, 16'h0, 3'd0, 1'b0), last_cyc + 1, "pulse_end");
    press(4'd0, ENT, 1'b1, mk(G_L, 2'd0, 16'h0, 3'd0, 1'b0), "relock3");
    enter4(16'h9876, G_L, 3'd0, mk(G_O, 2'd0, 16'h0, 3'd0, 1'b0), "open_9876");
    press(4'd0, ENT, 1'b1, mk(G_L, 2'd0, 16'h0, 3'd0, 1'b0), "relock4");
    enter4(16'h1234, G_L, 3'd0, mk(G_W, 2'd0, 16'h0, 3'd1, 1'b0), "old_code_wrong");
    push(mk(G_L, 2'd0, 16'h0, 3'd1, 1'b0), last_cyc + 200, "old_code_exit");
    drain(300, "new_code");

    // Clear beats enter; out-of-range digit, idle clear, stray change ignored.
    press(4'd1, ENT, 1'b1, mk(G_L, 2'd1, 16'h1000, 3'd1, 1'b0), "clr_d0");
    press(4'd2, ENT, 1'b1, mk(G_L, 2'd2, 16'h1200, 3'd1, 1'b0), "clr_d1");
    press(4'd3, CLR | ENT, 1'b1, mk(G_L, 2'd0, 16'h0, 3'd1, 1'b0), "clear_wins");
    press(4'hA, ENT, 1'b0, '0, "");
    press(4'd0, CLR, 1'b0, '0, "");
    press(4'd1, CHG, 1'b0, '0, "");
    drain(10, "clear");

    // Enter beats change in OPEN.
    enter4(16'h9876, G_L, 3'd1, mk(G_O, 2'd0, 16'h0, 3'd0, 1'b0), "open3");
    press(4'd0, CHG | ENT, 1'b1, mk(G_L, 2'd0, 16'h0, 3'd0, 1'b0), "enter_wins");

    // Into lockout again, then reset mid-lockout with enter held.
    enter4(16'h5555, G_L, 3'd0, mk(G_W, 2'd0, 16'h0, 3'd1, 1'b0), "w3");
    push(mk(G_L, 2'd0, 16'h0, 3'd1, 1'b0), last_cyc + 200, "w3_exit");
    drain(300, "w3");
    enter4(16'h5555, G_L, 3'd1, mk(G_W, 2'd0, 16'h0, 3'd2, 1'b0), "w4");
    push(mk(G_L, 2'd0, 16'h0, 3'd2, 1'b0), last_cyc + 200, "w4_exit");
    drain(300, "w4");
    enter4(16'h5555, G_L, 3'd2, mk(G_X, 2'd0, 16'h0, 3'd3, 1'b0), "lockout2");
    drain(10, "lockout2");
    repeat (20) @(negedge clk);
    #2;
    reset = 1'b1;
    btn_enter = 1'b1;
    push(mk(G_L, 2'd0, 16'h0, 3'd0, 1'b0), cyc + 1, "reset_in_lockout");
    #1;
    check_now(mk(G_L, 2'd0, 16'h0, 3'd0, 1'b0), "reset_async");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    btn_enter = 1'b0;
    repeat (4) @(negedge clk);
    drain(5, "held_enter");

    // Stored code reverted to the default by reset.
    enter4(16'h1234, G_L, 3'd0, mk(G_O, 2'd0, 16'h0, 3'd0, 1'b0), "default_restored");
    repeat (5) @(negedge clk);
    drain(10, "final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
